// File: rtl/x_23k640_pkg.sv
// Shared constants, state encoding and frame builder for the 23K640 SPI master.
package x_23k640_pkg;

    localparam logic [7:0] INSTR_READ  = 8'h03;
    localparam logic [7:0] INSTR_WRITE = 8'h02;
    localparam logic [7:0] INSTR_WRSR  = 8'h01;

    // Status register value: byte mode, HOLD disabled
    localparam logic [7:0] SR_INIT_VAL = 8'h01;

    localparam int FRAME_BITS = 32;
    localparam int INIT_BITS  = 16;
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_SHIFT,
        ST_END
    } state_e;

    // Build the 32-bit {instr, addr, data} shift frame for a byte access
    function automatic logic [31:0] build_frame(input logic        rd_n_wr,
                                                input logic [15:0] addr,
                                                input logic [7:0]  wdata);
        logic [7:0] instr;
        instr = rd_n_wr ? INSTR_READ : INSTR_WRITE;
        return {instr, addr, wdata};
    endfunction

endpackage

// File: rtl/x_23k640_sck_gen.sv
// Half-period timer for the SPI clock. Emits one-cycle rise/fall strobes while
// enabled; counter and phase restart from zero whenever the enable drops so the
// first rise always lands p_clk_div cycles after enable goes high.
module x_23k640_sck_gen
    import x_23k640_pkg::*;
#(
    parameter int p_clk_div = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(p_clk_div - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic             wrap;

    // Next-count and strobe decode
    always_comb begin
        wrap    = i_en && (cnt_q == LAST);
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!i_en) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (wrap) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        o_rise = wrap && !phase_q;
        o_fall = wrap && phase_q;
    end

    // Counter and phase registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/x_23k640.sv
// SPI master for one 23K640 serial SRAM in byte mode.
// Optional build macro X_23K640_MODE_INIT_EN: when defined, a WRSR (01 01)
// transaction is issued after reset before any request is accepted.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_INIT  | load the WRSR init frame (only reachable with the macro)
// ST_IDLE  | wait for i_valid, accept and load the request frame
// ST_SHIFT | CS low, 2 * nbits SCK half-periods, MSB first
// ST_END   | CS high for p_clk_div cycles before the next request
module x_23k640
    import x_23k640_pkg::*;
#(
    parameter int p_clk_div = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic       i_rd_n_wr,
    input  logic [15:0] i_addr,
    input  logic [7:0] i_wdata,
    output logic       o_accept,
    output logic       o_ready,
    output logic [7:0] o_rdata,
    output logic       o_sck,
    output logic       o_cs_n,
    output logic       o_mosi,
    input  logic       i_miso
);

    localparam logic [CNT_W-1:0] END_LAST = CNT_W'(p_clk_div - 1);

`ifdef X_23K640_MODE_INIT_EN
    localparam state_e RESET_STATE = ST_INIT;
`else
    localparam state_e RESET_STATE = ST_IDLE;
`endif

    state_e           state_q, state_d;
    logic [31:0]      sr_q, sr_d;
    logic [7:0]       rx_q, rx_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] end_cnt_q, end_cnt_d;
    logic             sck_q, sck_d;
    logic             cs_n_q, cs_n_d;
    logic             ready_q, ready_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             is_rd_q, is_rd_d;
    logic             init_q, init_d;
    logic             sck_en;
    logic             sck_rise;
    logic             sck_fall;

    assign sck_en = (state_q == ST_SHIFT);

    x_23k640_sck_gen #(
        .p_clk_div (p_clk_div)
    ) u_sck_gen (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (sck_en),
        .o_rise (sck_rise),
        .o_fall (sck_fall)
    );

    // Next-state, shift and handshake logic
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        rx_d      = rx_q;
        bit_cnt_d = bit_cnt_q;
        end_cnt_d = end_cnt_q;
        sck_d     = sck_q;
        cs_n_d    = cs_n_q;
        ready_d   = 1'b0;
        rdata_d   = rdata_q;
        is_rd_d   = is_rd_q;
        init_d    = init_q;
        o_accept  = 1'b0;

        case (state_q)
            ST_INIT: begin
                sr_d      = {INSTR_WRSR, SR_INIT_VAL, 16'h0000};
                bit_cnt_d = 5'(INIT_BITS - 1);
                cs_n_d    = 1'b0;
                is_rd_d   = 1'b0;
                init_d    = 1'b1;
                state_d   = ST_SHIFT;
            end
            ST_IDLE: begin
                // Gated by reset so a request is never acknowledged and then lost
                if (i_valid && !i_rst) begin
                    o_accept  = 1'b1;
                    sr_d      = build_frame(i_rd_n_wr, i_addr, i_wdata);
                    bit_cnt_d = 5'(FRAME_BITS - 1);
                    cs_n_d    = 1'b0;
                    is_rd_d   = i_rd_n_wr;
                    init_d    = 1'b0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sck_rise) begin
                    sck_d = 1'b1;
                    rx_d  = {rx_q[6:0], i_miso};
                end
                if (sck_fall) begin
                    sck_d = 1'b0;
                    if (bit_cnt_q == 5'd0) begin
                        cs_n_d    = 1'b1;
                        end_cnt_d = END_LAST;
                        state_d   = ST_END;
                        if (!init_q) begin
                            ready_d = 1'b1;
                            if (is_rd_q) begin
                                rdata_d = rx_q;
                            end
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q - 5'd1;
                        sr_d      = {sr_q[30:0], 1'b0};
                    end
                end
            end
            ST_END: begin
                if (end_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    end_cnt_d = end_cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= RESET_STATE;
            sr_q      <= '0;
            rx_q      <= '0;
            bit_cnt_q <= '0;
            end_cnt_q <= '0;
            sck_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            is_rd_q   <= 1'b0;
            init_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            rx_q      <= rx_d;
            bit_cnt_q <= bit_cnt_d;
            end_cnt_q <= end_cnt_d;
            sck_q     <= sck_d;
            cs_n_q    <= cs_n_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            is_rd_q   <= is_rd_d;
            init_q    <= init_d;
        end
    end

    // MOSI is the frame MSB, forced low whenever CS is not driven
    assign o_mosi  = sr_q[31] && (state_q == ST_SHIFT);
    assign o_sck   = sck_q;
    assign o_cs_n  = cs_n_q;
    assign o_ready = ready_q;
    assign o_rdata = rdata_q;

endmodule

// File: tb/tb_x_23k640.sv
// Self-checking bench for x_23k640 with a bit-level 23K640 model and a
// scoreboard of expected frames / read data. Honours X_23K640_MODE_INIT_EN.
module tb_x_23k640;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        rd = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic        miso = 1'b0;
    logic        o_accept, o_ready, o_sck, o_cs_n, o_mosi;
    logic [7:0]  o_rdata;

    always #5 clk = ~clk;

    x_23k640 #(.p_clk_div(DIV)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_valid   (valid),
        .i_rd_n_wr (rd),
        .i_addr    (addr),
        .i_wdata   (wdata),
        .o_accept  (o_accept),
        .o_ready   (o_ready),
        .o_rdata   (o_rdata),
        .o_sck     (o_sck),
        .o_cs_n    (o_cs_n),
        .o_mosi    (o_mosi),
        .i_miso    (miso)
    );

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- SRAM model ----------------
    typedef struct {
        logic [31:0] bits;
        int          n;
    } frame_t;

    frame_t      frm_q[$];
    logic [7:0]  sram_byte = 8'h00;
    logic [31:0] cap = '0;
    int          cap_n = 0;
    int          fall_n = 0;
    logic        prev_sck = 1'b0;
    logic        prev_cs = 1'b1;

    always @(o_sck or o_cs_n) begin
        if (prev_cs === 1'b1 && o_cs_n === 1'b0) begin
            cap = '0; cap_n = 0; fall_n = 0; miso = 1'b0;
        end
        if (prev_cs === 1'b0 && o_cs_n === 1'b1)
            frm_q.push_back('{cap, cap_n});
        if (prev_sck === 1'b0 && o_sck === 1'b1 && o_cs_n === 1'b0) begin
            cap = {cap[30:0], o_mosi};
            cap_n++;
        end
        if (prev_sck === 1'b1 && o_sck === 1'b0) begin
            fall_n++;
            if (fall_n >= 24 && fall_n < 32) miso = sram_byte[31 - fall_n];
        end
        prev_sck = o_sck;
        prev_cs  = o_cs_n;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] frame;
        logic [7:0]  rdata;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] rdata_model = 8'h00;
    int         n_acc = 0, n_rdy = 0, acc_cyc = 0, rdy_cyc = 0;

    always @(negedge clk) begin
        exp_t   e;
        frame_t f;
        if (o_accept === 1'b1) begin
            n_acc++;
            acc_cyc = cyc;
            if (rd) rdata_model = sram_byte;
            exp_q.push_back('{{(rd ? 8'h03 : 8'h02), addr, wdata}, rdata_model});
        end
        if (o_ready === 1'b1) begin
            n_rdy++;
            rdy_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk_val("ready_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk_val("rdata", {24'h0, o_rdata}, {24'h0, e.rdata});
                chk_val("ready_latency", cyc - acc_cyc, 1 + 64 * DIV);
                chk_val("cs_n_at_ready", {31'h0, o_cs_n}, 32'd1);
                chk_val("sck_at_ready", {31'h0, o_sck}, 32'd0);
                if (frm_q.size() == 0) begin
                    chk_val("frame_missing", 32'd0, 32'd1);
                end else begin
                    f = frm_q.pop_front();
                    chk_val("mosi_frame", f.bits, e.frame);
                    chk_val("mosi_nbits", f.n, 32);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic r, input logic [15:0] a, input logic [7:0] d,
                        input logic [7:0] sb, input bit keep);
        int a0, t;
        a0 = n_acc;
        t = 0;
        rd = r; addr = a; wdata = d; sram_byte = sb; valid = 1'b1;
        while (n_acc == a0 && t < 2000) begin
            tick();
            t++;
        end
        if (n_acc == a0) chk_val("accept_timeout", 32'd0, 32'd1);
        if (!keep) valid = 1'b0;
    endtask

    task automatic wait_rdy();
        int r0, t;
        r0 = n_rdy;
        t = 0;
        while (n_rdy == r0 && t < 1000) begin
            tick();
            t++;
        end
        if (n_rdy == r0) chk_val("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_init();
        int t;
        frame_t f;
        t = 0;
        while (frm_q.size() == 0 && t < 1000) begin
            tick();
            t++;
        end
        if (frm_q.size() == 0) begin
            chk_val("init_timeout", 32'd0, 32'd1);
        end else begin
            f = frm_q.pop_front();
            chk_val("init_frame", f.bits, 32'h0000_0101);
            chk_val("init_nbits", f.n, 16);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a0, r0, t;

        tick(3);
        chk_val("rst_cs_n", {31'h0, o_cs_n}, 32'd1);
        chk_val("rst_sck", {31'h0, o_sck}, 32'd0);
        chk_val("rst_mosi", {31'h0, o_mosi}, 32'd0);
        chk_val("rst_ready", {31'h0, o_ready}, 32'd0);
        chk_val("rst_rdata", {24'h0, o_rdata}, 32'h0);
        frm_q.delete();
        rst = 1'b0;

`ifdef X_23K640_MODE_INIT_EN
        // Request pending from reset release: must wait for the init frame
        rd = 1'b1; addr = 16'h0042; wdata = 8'h00; sram_byte = 8'hC3; valid = 1'b1;
        a0 = n_acc;
        wait_init();
        chk_val("accept_blocked_init", n_acc - a0, 0);
        send(1'b1, 16'h0042, 8'h00, 8'hC3, 1'b0);
        wait_rdy();
`endif

        // Write with cycle-accurate edge placement
        send(1'b0, 16'h1234, 8'hA5, 8'h00, 1'b0);
        chk_val("cs_fall_T1", {31'h0, o_cs_n}, 32'd0);
        chk_val("mosi_bit31", {31'h0, o_mosi}, 32'd0);
        tick(DIV - 1);
        chk_val("sck_low_before_rise", {31'h0, o_sck}, 32'd0);
        tick();
        chk_val("sck_first_rise", {31'h0, o_sck}, 32'd1);
        wait_rdy();

        // Read, rdata held afterwards
        send(1'b1, 16'h0010, 8'h00, 8'h5C, 1'b0);
        wait_rdy();
        tick(10);
        chk_val("rdata_hold", {24'h0, o_rdata}, 32'h5C);

        // Back-to-back: valid held across two requests
        send(1'b1, 16'hE001, 8'h11, 8'h3C, 1'b1);
        send(1'b0, 16'h7FFF, 8'h96, 8'h3C, 1'b0);
        chk_val("b2b_gap", acc_cyc - rdy_cyc, DIV);
        wait_rdy();

        // Busy: valid toggling with changing fields during SHIFT
        send(1'b0, 16'hBEEF, 8'h5A, 8'h3C, 1'b0);
        a0 = n_acc;
        for (int i = 0; i < 100; i++) begin
            valid = i[0];
            rd = i[1];
            addr = 16'(i * 16'h0101);
            wdata = 8'(i);
            tick();
        end
        valid = 1'b0;
        chk_val("busy_no_accept", n_acc - a0, 0);
        wait_rdy();
        chk_val("rdata_after_write", {24'h0, o_rdata}, 32'h3C);

        // Reset mid-read while SCK is high (21 edges seen)
        send(1'b1, 16'h0777, 8'h00, 8'h99, 1'b0);
        t = 0;
        while ((cap_n + fall_n) < 21 && t < 1000) begin
            tick();
            t++;
        end
        chk_val("abort_sck_high", {31'h0, o_sck}, 32'd1);
        r0 = n_rdy;
        rst = 1'b1;
        tick();
        chk_val("abort_cs_n", {31'h0, o_cs_n}, 32'd1);
        chk_val("abort_sck", {31'h0, o_sck}, 32'd0);
        chk_val("abort_rdata", {24'h0, o_rdata}, 32'h0);
        rst = 1'b0;
        exp_q.delete();
        frm_q.delete();
        rdata_model = 8'h00;
`ifdef X_23K640_MODE_INIT_EN
        wait_init();
`endif
        tick(300);
        chk_val("abort_no_ready", n_rdy - r0, 0);

        // Read after the abort
        send(1'b1, 16'h1FF0, 8'h00, 8'hE7, 1'b0);
        wait_rdy();
        tick(DIV + 2);
        chk_val("post_abort_rdata", {24'h0, o_rdata}, 32'hE7);
        chk_val("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
